// File: rtl/quiz_pkg.sv
// Shared types and constants for the quiz display sequencer: state codes,
// seven-segment glyphs (abcdefg, bit6=a .. bit0=g, active-high).
package quiz_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_SHOW_A  = 3'd1;
  localparam state_t ST_GAP_A   = 3'd2;
  localparam state_t ST_SHOW_B  = 3'd3;
  localparam state_t ST_GAP_B   = 3'd4;
  localparam state_t ST_SHOW_RT = 3'd5;
  localparam state_t ST_GAP_RT  = 3'd6;
  localparam state_t ST_SHOW_RO = 3'd7;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_DASH  = 7'h01;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Any digit code above 9 renders as a dash; this one is used on purpose.
  localparam logic [3:0] DIGIT_DASH = 4'hF;

endpackage

// File: rtl/quiz_display_seq_if.sv
// Bus between the question generator (master) and the display sequencer (slave).
//
// Handshake: the master holds load high with opnd_a/opnd_b/result stable; the
// transfer happens on the rising clock edge where load && ready && !clear.
// ready is high only while the sequencer is idle; load while ready=0 is
// dropped, never queued. clear is a synchronous abort with priority over load.
interface quiz_display_seq_if;
  import quiz_pkg::*;

  logic       load;
  logic       clear;
  logic [3:0] opnd_a;
  logic [3:0] opnd_b;
  logic [6:0] result;
  logic       ready;
  logic       busy;
  logic       done;
  logic [6:0] num_led;
  state_t     dbg_state;

  modport master (
    output load, clear, opnd_a, opnd_b, result,
    input  ready, busy, done, num_led, dbg_state
  );

  modport slave (
    input  load, clear, opnd_a, opnd_b, result,
    output ready, busy, done, num_led, dbg_state
  );

endinterface

// File: rtl/seg7_encode.sv
// Combinational 4-bit digit to seven-segment glyph; codes above 9 give a dash.
module seg7_encode
  import quiz_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Glyph lookup.
  always_comb begin
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/quiz_display_seq.sv
// Quiz display sequencer: captures one A/B/result set and plays it on a single
// seven-segment digit as A, B, result tens (skipped when zero), result ones,
// each held for HOLD_CYCLES with GAP_CYCLES of blank in between.
module quiz_display_seq
  import quiz_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 5_000_000,
  parameter int CNT_W       = 26
) (
  input  logic                clk,
  input  logic                reset,
  quiz_display_seq_if.slave   bus
);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         cap_a;
  logic [3:0]         cap_b;
  logic [6:0]         cap_r;
  logic [3:0]         cap_a_nxt;
  logic [3:0]         cap_b_nxt;
  logic [6:0]         cap_r_nxt;
  logic [6:0]         led_q;
  logic [6:0]         led_nxt;
  logic [6:0]         seg;
  logic [6:0]         rem;
  logic [3:0]         tens;
  logic [3:0]         ones;
  logic [3:0]         digit;
  logic               show;
  logic               accept;
  logic               hold_end;
  logic               gap_end;
  logic               r_big;

  assign accept   = (state == ST_IDLE) && bus.load && !bus.clear;
  assign hold_end = (cnt == CNT_W'(HOLD_CYCLES - 1));
  assign gap_end  = (cnt == CNT_W'(GAP_CYCLES - 1));

  // Next value of the capture registers: load on accept, drop on clear.
  always_comb begin
    cap_a_nxt = cap_a;
    cap_b_nxt = cap_b;
    cap_r_nxt = cap_r;
    if (bus.clear) begin
      cap_a_nxt = '0;
      cap_b_nxt = '0;
      cap_r_nxt = '0;
    end else if (accept) begin
      cap_a_nxt = bus.opnd_a;
      cap_b_nxt = bus.opnd_b;
      cap_r_nxt = bus.result;
    end
  end

  // Tens/ones split by repeated compare-subtract; nine steps cover 0..99.
  always_comb begin
    rem  = cap_r_nxt;
    tens = '0;
    for (int i = 0; i < 9; i++) begin
      if (rem >= 7'd10) begin
        rem  = rem - 7'd10;
        tens = tens + 4'd1;
      end
    end
    ones  = rem[3:0];
    r_big = (cap_r_nxt > 7'd99);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; clear overrides everything.
  always_comb begin
    state_nxt = state;
    if (bus.clear) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (bus.load) state_nxt = ST_SHOW_A;
        ST_SHOW_A:  if (hold_end) state_nxt = ST_GAP_A;
        ST_GAP_A:   if (gap_end)  state_nxt = ST_SHOW_B;
        ST_SHOW_B:  if (hold_end) state_nxt = ST_GAP_B;
        ST_GAP_B:   if (gap_end)  state_nxt = (cap_r >= 7'd10) ? ST_SHOW_RT : ST_SHOW_RO;
        ST_SHOW_RT: if (hold_end) state_nxt = ST_GAP_RT;
        ST_GAP_RT:  if (gap_end)  state_nxt = ST_SHOW_RO;
        ST_SHOW_RO: if (hold_end) state_nxt = ST_IDLE;
        default:                  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs: status from the current state, glyph digit from the next state
  // so the registered display lines up with the state it belongs to.
  always_comb begin
    bus.ready     = (state == ST_IDLE);
    bus.busy      = (state != ST_IDLE);
    bus.done      = (state == ST_SHOW_RO) && hold_end;
    bus.dbg_state = state;
    digit         = DIGIT_DASH;
    show          = 1'b1;
    case (state_nxt)
      ST_SHOW_A:  digit = cap_a_nxt;
      ST_SHOW_B:  digit = cap_b_nxt;
      ST_SHOW_RT: digit = r_big ? DIGIT_DASH : tens;
      ST_SHOW_RO: digit = r_big ? DIGIT_DASH : ones;
      default:    show  = 1'b0;
    endcase
  end

  seg7_encode u_enc (
    .digit (digit),
    .seg   (seg)
  );

  assign led_nxt     = show ? seg : SEG_BLANK;
  assign bus.num_led = led_q;

  // Dwell counter, capture registers and display register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      cap_a <= '0;
      cap_b <= '0;
      cap_r <= '0;
      led_q <= SEG_BLANK;
    end else begin
      cap_a <= cap_a_nxt;
      cap_b <= cap_b_nxt;
      cap_r <= cap_r_nxt;
      led_q <= led_nxt;
      if ((state_nxt != state) || (state_nxt == ST_IDLE)) cnt <= '0;
      else                                                cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_quiz_display_seq.sv
// Bench for quiz_display_seq with short dwell times (hold 4, gap 2).
`timescale 1ns/1ps
module tb_quiz_display_seq;

  localparam int HOLD  = 4;
  localparam int GAP   = 2;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [6:0] exp_q[$];
  logic [6:0] glyph_tab [10];

  quiz_display_seq_if bus();

  quiz_display_seq #(
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP),
    .CNT_W       (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model: glyph of a value as the display should show it.
  function automatic logic [6:0] glyph(input int v);
    if (v > 9) return 7'h01;
    return glyph_tab[v];
  endfunction

  // Reference model: cycle-by-cycle expected num_led for one sequence.
  task automatic build_expected(input int a, input int b, input int r);
    logic [6:0] g[$];
    exp_q.delete();
    g.push_back(glyph(a));
    g.push_back(glyph(b));
    if (r > 99) begin
      g.push_back(7'h01);
      g.push_back(7'h01);
    end else begin
      if (r / 10 != 0) g.push_back(glyph(r / 10));
      g.push_back(glyph(r % 10));
    end
    for (int k = 0; k < g.size(); k++) begin
      repeat (HOLD) exp_q.push_back(g[k]);
      if (k != g.size() - 1) repeat (GAP) exp_q.push_back(7'h00);
    end
  endtask

  // Driver: at a negedge with the DUT idle, load one set and check the whole
  // playback. poke_at >= 0 pulses load with fresh data at that cycle index.
  task automatic run_seq(input int a, input int b, input int r, input string name,
                         input int poke_at);
    int n;
    int busy_cnt;
    int busy_exp;
    logic [6:0] e;
    busy_cnt = 0;
    busy_exp = (r < 10) ? (3 * HOLD + 2 * GAP) : (4 * HOLD + 3 * GAP);
    build_expected(a, b, r);
    n = exp_q.size();
    n_checks++;
    if (bus.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_before got %b want 1", name, bus.ready);
    end
    bus.load   = 1'b1;
    bus.opnd_a = 4'(a);
    bus.opnd_b = 4'(b);
    bus.result = 7'(r);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.load = 1'b0;
      if (i == poke_at) begin
        bus.load   = 1'b1;
        bus.opnd_a = 4'($urandom_range(0, 9));
        bus.opnd_b = 4'($urandom_range(0, 9));
        bus.result = 7'($urandom_range(0, 99));
      end
      e = exp_q.pop_front();
      n_checks++;
      if (bus.num_led !== e) begin
        n_fail++;
        $display("FAIL %s led[%0d] got %h want %h", name, i, bus.num_led, e);
      end
      n_checks++;
      if (bus.ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s ready[%0d] got %b want 0", name, i, bus.ready);
      end
      n_checks++;
      if (bus.done !== (i == n - 1)) begin
        n_fail++;
        $display("FAIL %s done[%0d] got %b want %b", name, i, bus.done, (i == n - 1));
      end
      if (bus.busy === 1'b1) busy_cnt++;
    end
    @(negedge clk);
    bus.load = 1'b0;
    n_checks++;
    if (busy_cnt != busy_exp) begin
      n_fail++;
      $display("FAIL %s busy_len got %0d want %0d", name, busy_cnt, busy_exp);
    end
    n_checks++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.num_led !== 7'h00) begin
      n_fail++;
      $display("FAIL %s idle_after got r%b b%b d%b led%h want r1 b0 d0 led00", name,
               bus.ready, bus.busy, bus.done, bus.num_led);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    bus.load   = 1'b0;
    bus.clear  = 1'b0;
    bus.opnd_a = '0;
    bus.opnd_b = '0;
    bus.result = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.num_led !== 7'h00) begin
      n_fail++;
      $display("FAIL reset_state got r%b b%b d%b led%h want r1 b0 d0 led00",
               bus.ready, bus.busy, bus.done, bus.num_led);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.ready !== 1'b1 || bus.num_led !== 7'h00) begin
      n_fail++;
      $display("FAIL reset_release got r%b led%h want r1 led00", bus.ready, bus.num_led);
    end
  endtask

  task automatic test_directed();
    run_seq(3, 4, 12, "case1", -1);
    run_seq(7, 2, 5, "case2", -1);
    run_seq(12, 9, 120, "case3", -1);
    run_seq(0, 0, 0, "zeros", -1);
    run_seq(9, 9, 99, "max_valid", -1);
    run_seq(5, 1, 10, "tens_edge", -1);
  endtask

  task automatic test_load_while_busy();
    run_seq(6, 8, 48, "load_busy", HOLD + GAP + 1);
  endtask

  task automatic test_back_to_back();
    run_seq(1, 2, 3, "b2b_first", -1);
    run_seq(4, 5, 20, "b2b_second", -1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      run_seq($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 127), "random", -1);
    end
  endtask

  task automatic test_clear();
    bus.load   = 1'b1;
    bus.opnd_a = 4'd3;
    bus.opnd_b = 4'd4;
    bus.result = 7'd12;
    for (int i = 0; i <= HOLD; i++) begin
      @(negedge clk);
      bus.load = 1'b0;
    end
    n_checks++;
    if (bus.num_led !== 7'h00 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_pre got led%h b%b want led00 b1", bus.num_led, bus.busy);
    end
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    n_checks++;
    if (bus.num_led !== 7'h00 || bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_gap got led%h r%b b%b d%b want led00 r1 b0 d0",
               bus.num_led, bus.ready, bus.busy, bus.done);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.num_led !== 7'h00 || bus.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_stay got led%h r%b want led00 r1", bus.num_led, bus.ready);
    end
    bus.clear  = 1'b1;
    bus.load   = 1'b1;
    bus.opnd_a = 4'd8;
    @(negedge clk);
    bus.clear = 1'b0;
    bus.load  = 1'b0;
    n_checks++;
    if (bus.ready !== 1'b1 || bus.num_led !== 7'h00) begin
      n_fail++;
      $display("FAIL clear_load got r%b led%h want r1 led00", bus.ready, bus.num_led);
    end
    @(negedge clk);
    n_checks++;
    if (bus.ready !== 1'b1 || bus.num_led !== 7'h00) begin
      n_fail++;
      $display("FAIL clear_load_hold got r%b led%h want r1 led00", bus.ready, bus.num_led);
    end
  endtask

  task automatic test_async_reset();
    int idx;
    idx = 4 * HOLD + 3 * GAP - 3;
    bus.load   = 1'b1;
    bus.opnd_a = 4'd3;
    bus.opnd_b = 4'd4;
    bus.result = 7'd12;
    for (int i = 0; i <= idx; i++) begin
      @(negedge clk);
      bus.load = 1'b0;
    end
    n_checks++;
    if (bus.num_led !== 7'h6D) begin
      n_fail++;
      $display("FAIL areset_pre got %h want 6d", bus.num_led);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.num_led !== 7'h00) begin
      n_fail++;
      $display("FAIL areset_mid got r%b b%b d%b led%h want r1 b0 d0 led00",
               bus.ready, bus.busy, bus.done, bus.num_led);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.ready !== 1'b1 || bus.num_led !== 7'h00) begin
      n_fail++;
      $display("FAIL areset_after got r%b led%h want r1 led00", bus.ready, bus.num_led);
    end
    run_seq(7, 2, 5, "after_reset", -1);
  endtask

  initial begin
    glyph_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
    test_reset();
    test_directed();
    test_load_while_busy();
    test_back_to_back();
    test_random();
    test_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
